beat_tone_gen: RTL and testbench

Consumer end of the beat-index interface. It watches the 12-bit beat index produced by the player beat counter and fetches that beat's note from a synchronous music ROM. From the note it synthesizes a square-wave tone and serializes the samples to the audio Pmod as a left-justified, 16-bit stereo stream. It sits between the player beat counter, the music ROM and the speaker pins.

---
 rtl/beat_tone_gen.sv | 192 +++++++++++++++++++
 tb/tb_beat_tone_gen.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_tone_gen.sv
// Purpose : fetch the note for the current beat from a synchronous music ROM,
//           turn it into a square-wave tone and serialize it as a
//           left-justified 16-bit stereo stream for the audio Pmod.
// Latency : beat change to note load takes 3 clk; tone to pins takes at most 512 clk.
// Backpressure: none. Beats that change during a fetch are picked up when the FSM returns to IDLE.
// Ports   : clk/reset (async active-low) | en, ibeat : player side
//           rom_addr -> / rom_data <- : music ROM, 1-cycle read
//           note_valid : 1-cycle pulse per loaded note
//           audio_mclk/sck/lrck/sdin : clk/4, clk/16, clk/512, serial data
module beat_tone_gen #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned DIV_W  = 22,
  parameter logic [15:0] AMP    = 16'h2000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [11:0]      ibeat,
  output logic [11:0]      rom_addr,
  input  logic [DIV_W-1:0] rom_data,
  output logic             note_valid,
  output logic             audio_mclk,
  output logic             audio_sck,
  output logic             audio_lrck,
  output logic             audio_sdin
);

  // The serializer ratios are fixed counter taps; CLK_HZ only documents the
  // clock they were chosen for. A zero clock has no meaning.
  if (CLK_HZ == 0) begin : g_clk_hz_zero
  end

  localparam logic [15:0] NEG_AMP = ~AMP + 16'd1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e state_q, state_d;

  logic [11:0]      prev_beat_q, prev_beat_d;
  logic             first_pending_q, first_pending_d;
  logic [11:0]      rom_addr_q, rom_addr_d;
  logic [DIV_W-1:0] half_period_q, half_period_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic             note_valid_q, note_valid_d;
  logic [8:0]       ck_q, ck_d;
  logic [15:0]      sr_q, sr_d;
  logic [15:0]      hold_q, hold_d;

  logic             beat_new;
  logic             fetch_go;
  logic             load_note;
  logic [15:0]      sample;

  // prev_beat holds the last fetched beat, so a change that arrives while a
  // fetch is in flight is still seen once the FSM is back in IDLE.
  assign beat_new = (ibeat != prev_beat_q) || first_pending_q;

  // ---------------- fetch FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- fetch FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (beat_new) state_d = S_REQ;
        S_REQ:   state_d = S_WAIT;
        S_WAIT:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- fetch FSM: outputs ----------------
  always_comb begin
    fetch_go  = 1'b0;
    load_note = 1'b0;
    if (en) begin
      case (state_q)
        S_IDLE:  fetch_go  = beat_new;
        S_WAIT:  load_note = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    prev_beat_d     = prev_beat_q;
    first_pending_d = first_pending_q;
    rom_addr_d      = rom_addr_q;
    half_period_d   = half_period_q;
    note_valid_d    = load_note;

    if (fetch_go) begin
      rom_addr_d      = ibeat;
      prev_beat_d     = ibeat;
      first_pending_d = 1'b0;
    end
    if (load_note) begin
      half_period_d = rom_data;
    end
    // Disabling silences the tone and forces a refetch of whatever beat is
    // current when play resumes; rom_addr keeps its last value.
    if (!en) begin
      half_period_d   = '0;
      first_pending_d = 1'b1;
    end
  end

  // Tone divider: sq toggles every half_period cycles; a rest parks it at 0.
  always_comb begin
    cnt_d = cnt_q;
    sq_d  = sq_q;
    if (load_note || (half_period_q == '0)) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (cnt_q == half_period_q - DIV_W'(1)) begin
      cnt_d = '0;
      sq_d  = ~sq_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_comb begin
    sample = '0;
    if (en && (half_period_q != '0)) begin
      sample = sq_q ? AMP : NEG_AMP;
    end
  end

  // Serializer: one 512-cycle frame, left word in ck 0..255, right in 256..511.
  // Loads happen on the last cycle of the previous word so the MSB is on the
  // pin for the whole first sck period; shifts happen as sck falls.
  always_comb begin
    ck_d   = ck_q + 9'd1;
    hold_d = hold_q;
    sr_d   = sr_q;
    if (ck_q == 9'd511) begin
      hold_d = sample;
      sr_d   = sample;
    end else if (ck_q == 9'd255) begin
      sr_d = hold_q;
    end else if (ck_q[3:0] == 4'hF) begin
      sr_d = {sr_q[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_beat_q     <= '0;
      first_pending_q <= 1'b1;
      rom_addr_q      <= '0;
      half_period_q   <= '0;
      cnt_q           <= '0;
      sq_q            <= 1'b0;
      note_valid_q    <= 1'b0;
      ck_q            <= '0;
      sr_q            <= '0;
      hold_q          <= '0;
    end else begin
      prev_beat_q     <= prev_beat_d;
      first_pending_q <= first_pending_d;
      rom_addr_q      <= rom_addr_d;
      half_period_q   <= half_period_d;
      cnt_q           <= cnt_d;
      sq_q            <= sq_d;
      note_valid_q    <= note_valid_d;
      ck_q            <= ck_d;
      sr_q            <= sr_d;
      hold_q          <= hold_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign note_valid = note_valid_q;
  assign audio_mclk = ck_q[1];
  assign audio_sck  = ck_q[3];
  assign audio_lrck = ck_q[8];
  assign audio_sdin = sr_q[15];

endmodule

// File: tb/tb_beat_tone_gen.sv
module tb_beat_tone_gen;

  localparam logic [15:0] POS_AMP = 16'h2000;
  localparam logic [15:0] NEG_AMP = 16'hE000;

  logic        clk;
  logic        reset;
  logic        en;
  logic [11:0] ibeat;
  logic [11:0] rom_addr;
  logic [21:0] rom_data;
  logic        note_valid;
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic        audio_sdin;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rel    = 0;

  typedef struct {
    logic [11:0] addr;
    int          cyc;
  } note_exp_t;

  // mode 0: exact value, mode 1: +AMP or -AMP, mode 2: equal to preceding left word
  typedef struct {
    logic        chan;
    int          mode;
    logic [15:0] val;
  } word_exp_t;

  note_exp_t   note_q[$];
  word_exp_t   word_q[$];
  logic [15:0] last_left = '0;

  beat_tone_gen #(
    .CLK_HZ(100_000_000),
    .DIV_W (22),
    .AMP   (16'h2000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .ibeat     (ibeat),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note_valid(note_valid),
    .audio_mclk(audio_mclk),
    .audio_sck (audio_sck),
    .audio_lrck(audio_lrck),
    .audio_sdin(audio_sdin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [21:0] rom_val(input logic [11:0] a);
    case (a)
      12'd0:    return 22'd10;
      12'd3:    return 22'd5;
      12'd4:    return 22'd6;
      12'd5:    return 22'd3;
      12'd7:    return 22'd4;
      12'd9:    return 22'd0;
      12'd4094: return 22'd8;
      default:  return 22'd2;
    endcase
  endfunction

  // Synchronous music ROM: one-cycle read latency.
  initial begin
    rom_data = '0;
    forever begin
      @(posedge clk);
      rom_data <= rom_val(rom_addr);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- note monitor ----------------
  initial begin
    note_exp_t ne;
    forever begin
      @(negedge clk);
      if (note_valid === 1'b1) begin
        checks++;
        if (note_q.size() == 0) begin
          errors++;
          $display("FAIL note_unexpected: pulse at cycle %0d rom_addr=%0d, none expected", cyc, rom_addr);
        end else begin
          ne = note_q.pop_front();
          if ((rom_addr !== ne.addr) || (cyc != ne.cyc)) begin
            errors++;
            $display("FAIL note_%0d: got addr %0d at cycle %0d, expected addr %0d at cycle %0d",
                     ne.addr, rom_addr, cyc, ne.addr, ne.cyc);
          end
        end
      end
    end
  end

  // ---------------- word monitor: deserializes sdin on sck rising ----------------
  task automatic word_done(input logic ch, input logic [15:0] w);
    word_exp_t we;
    logic      ok;
    if ((word_q.size() != 0) && (word_q[0].chan == ch)) begin
      we = word_q.pop_front();
      checks++;
      case (we.mode)
        0:       ok = (w == we.val);
        1:       ok = (w == POS_AMP) || (w == NEG_AMP);
        default: ok = (w == last_left);
      endcase
      if (!ok) begin
        errors++;
        $display("FAIL word_ch%0d_mode%0d: got 0x%04h, expected 0x%04h (left=0x%04h)",
                 ch, we.mode, w, we.val, last_left);
      end
    end
    if (ch == 1'b0) last_left = w;
  endtask

  initial begin
    logic [15:0] sh;
    int          bitcnt;
    logic        cur_lr;
    logic        sck_prev;
    sh = '0; bitcnt = 0; cur_lr = 1'b0; sck_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        bitcnt = 0; cur_lr = 1'b0; sck_prev = 1'b0;
      end else begin
        if (audio_lrck !== cur_lr) begin
          cur_lr = audio_lrck;
          bitcnt = 0;
        end
        if (audio_sck && !sck_prev) begin
          sh = {sh[14:0], audio_sdin};
          bitcnt++;
          if (bitcnt == 16) begin
            word_done(cur_lr, sh);
            bitcnt = 0;
          end
        end
        sck_prev = audio_sck;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_note(input logic [11:0] a, input int at_cyc);
    note_exp_t ne;
    ne.addr = a;
    ne.cyc  = at_cyc;
    note_q.push_back(ne);
  endtask

  task automatic push_words(input int mode, input logic [15:0] v);
    word_exp_t we;
    we.chan = 1'b0; we.mode = mode; we.val = v;
    word_q.push_back(we);
    we.chan = 1'b1; we.mode = (mode == 1) ? 2 : mode;
    word_q.push_back(we);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int t = 0; t < budget; t++) begin
      if ((note_q.size() == 0) && (word_q.size() == 0)) break;
      @(negedge clk);
    end
    checks++;
    if ((note_q.size() != 0) || (word_q.size() != 0)) begin
      errors++;
      $display("FAIL %s_timeout: %0d notes and %0d words still pending, expected 0",
               name, note_q.size(), word_q.size());
      note_q.delete();
      word_q.delete();
    end
  endtask

  // Expected framing after reset release: ck equals cycles since release.
  task automatic check_framing(input int nmax);
    int k;
    for (int n = 1; n <= nmax; n++) begin
      @(negedge clk);
      k = cyc - rel;
      check($sformatf("framing_k%0d", k),
            {28'b0, audio_mclk, audio_sck, audio_lrck, audio_sdin},
            {28'b0, 1'(k >> 1), 1'(k >> 3), 1'(k >> 8), 1'b0});
    end
  endtask

  task automatic wait_ck(input int n);
    for (int t = 0; t < 1024; t++) begin
      @(negedge clk);
      if (((cyc - rel) & 511) == n) break;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int c;
    reset = 1'b1;
    en    = 1'b0;
    ibeat = 12'd0;
    #2 reset = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_rom_addr", {20'b0, rom_addr}, 32'd0);
    check("reset_outputs", {27'b0, note_valid, audio_mclk, audio_sck, audio_lrck, audio_sdin}, 32'd0);

    // Release with en=0: free-running framing, silent data, no note pulses.
    reset = 1'b1;
    rel   = cyc;
    check_framing(300);

    // Single fetch of beat 7 (half-period 4).
    @(negedge clk);
    ibeat = 12'd7;
    en    = 1'b1;
    c     = cyc;
    push_note(12'd7, c + 3);
    @(negedge clk);
    check("rom_addr_after_e0", {20'b0, rom_addr}, 32'd7);
    @(negedge clk);
    for (int i = 3; i <= 11; i++) begin
      @(negedge clk);
      check($sformatf("sq_phase_%0d", i), {31'b0, dut.sq_q}, {31'b0, 1'((i >= 7) && (i <= 10))});
    end
    repeat (1100) @(negedge clk);
    push_words(1, 16'h0000);
    wait_drain("tone7", 1500);

    // Rest note: both channels silent.
    @(negedge clk);
    ibeat = 12'd9;
    push_note(12'd9, cyc + 3);
    repeat (1100) @(negedge clk);
    push_words(0, 16'h0000);
    wait_drain("rest9", 1500);

    // Beat changes 3 -> 4 during the fetch of 3.
    @(negedge clk);
    ibeat = 12'd3;
    c     = cyc;
    push_note(12'd3, c + 3);
    push_note(12'd4, c + 6);
    @(negedge clk);
    ibeat = 12'd4;
    wait_drain("midfetch", 50);

    // Enable drop: silence, no pulses, beat moved while disabled.
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    ibeat = 12'd4094;
    repeat (1100) @(negedge clk);
    push_words(0, 16'h0000);
    wait_drain("disabled", 1500);

    // Re-enable with unchanged beat: refetch 4094.
    @(negedge clk);
    en = 1'b1;
    push_note(12'd4094, cyc + 3);
    repeat (1100) @(negedge clk);
    push_words(1, 16'h0000);
    wait_drain("reenable", 1500);

    // Beat index wraps to 0.
    @(negedge clk);
    ibeat = 12'd0;
    push_note(12'd0, cyc + 3);
    repeat (4) @(negedge clk);
    check("rom_addr_wrap", {20'b0, rom_addr}, 32'd0);
    wait_drain("wrap", 50);

    // Async reset while in WAIT at ck==300.
    wait_ck(298);
    ibeat = 12'd5;
    @(negedge clk);
    check("rom_addr_pre_reset", {20'b0, rom_addr}, 32'd5);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_rom_addr", {20'b0, rom_addr}, 32'd0);
    check("async_outputs", {27'b0, note_valid, audio_mclk, audio_sck, audio_lrck, audio_sdin}, 32'd0);
    repeat (3) @(negedge clk);
    check("async_held", {15'b0, rom_addr, note_valid, audio_mclk, audio_sck, audio_lrck, audio_sdin}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rel   = cyc;
    push_note(12'd5, cyc + 3);
    check_framing(300);
    wait_drain("post_reset", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
